decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
- Sequencer that drives the 3-bit select inputs (SW0/SW1/SW2) of the 3-to-8 LED decoder.
- Replaces the hand-set switches with a programmable scan: manual, count up, count down or ping-pong.
- Steps at a prescaled rate or on a debounced single-step button.
- Sits between board switches/buttons and the decoder instance in the board top.

Parameters:
- TICK_DIV, 50000000, clock cycles per automatic step (≥2).
- DEB_CYCLES, 1000000, consecutive stable cycles required before a debounced input changes (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- SW_in  input  3  raw board switches {SW2,SW1,SW0}, asynchronous.
- step_btn  input  1  raw single-step push button, asynchronous, active-high.
- mode  input  2  00 MANUAL, 01 UP, 10 DOWN, 11 PINGPONG; synchronous to clk.
- run  input  1  enables automatic stepping; synchronous to clk.
- sel  output  3  decoder select; bit0→SW0, bit1→SW1, bit2→SW2.
- dir  output  1  current direction, 0 = up, 1 = down.
- tick  output  1  one-cycle pulse on every cycle in which sel is loaded with a new value.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: sel=0, dir=0, tick=0. Prescaler, debounce counters and debounced values are all 0. Reset mid-scan aborts immediately and the scan restarts from sel=0.
- Input conditioning (SW_in[2:0] and step_btn):
  - Each input has a 2-flop synchroniser followed by a debouncer.
  - The debounced value takes the synchronised value once that value has differed from it for DEB_CYCLES consecutive cycles.
  - Any return to the old value clears the counter.
  - Latency from a clean raw edge to the debounced change: DEB_CYCLES+2 cycles.
- step_ev: single-cycle pulse on the rising edge of debounced step_btn.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1 and mode≠MANUAL, and is held at 0 otherwise.
  - auto_ev fires in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - First auto_ev arrives TICK_DIV cycles after run rises.
- adv = (auto_ev | step_ev) & (mode≠MANUAL). Simultaneous auto_ev and step_ev produce exactly one advance.
- Next-select rules, registered, applied in the cycle after adv:
  - UP: sel+1 mod 8 (7→0); dir←0.
  - DOWN: sel−1 mod 8 (0→7); dir←1.
  - PINGPONG:
    - dir=0 and sel<7 → sel+1.
    - dir=0 and sel=7 → sel=6, dir←1.
    - dir=1 and sel>0 → sel−1.
    - dir=1 and sel=0 → sel=1, dir←0.
    - Entering PINGPONG keeps the current dir.
- MANUAL:
  - Each cycle, sel←debounced SW_in and dir←0.
  - tick pulses whenever the loaded value differs from the current sel.
- Mode change:
  - Takes effect on the next clock edge.
  - Entering MANUAL loads the debounced switches in that same update.
  - Leaving MANUAL continues from the current sel.
  - The prescaler restarts from 0 on every mode change.
- run deasserting mid-count clears the prescaler; step_btn still advances while run=0 in non-MANUAL modes.
- tick is registered alongside sel, so tick=1 in exactly the cycle sel shows its new value.

Decomposition:
- Shared package: mode encodings (MODE_MANUAL/UP/DOWN/PINGPONG), SEL_W=3, DIR_UP/DIR_DN constants.
- One sub-module: sync_debounce. Parameter DEB_CYCLES; ports clk, rst_n, raw, clean. Instantiated 4×.
- Prescaler, step edge detect and next-select logic stay in decoder_scan_ctrl.

Test Plan:
- All scenarios use TICK_DIV=4, DEB_CYCLES=3.
- Reset then UP, run=1: sel steps 0,1,…,7,0 with one step every 4 cycles; tick pulses once per step; dir=0 throughout.
- PINGPONG from sel=5, dir=0, run=1: sel sequence 6,7,6,5,…,0,1; dir goes 1 on 7→6 and 0 on 0→1.
- MANUAL:
  - SW_in=3'b101 held clean → sel=5 exactly 6 cycles after the edge (sync + debounce + register), one tick.
  - A 2-cycle glitch on SW_in → sel unchanged, no tick.
- DOWN, run=0, step_btn pulses:
  - Each clean press held ≥4 cycles → sel decrements once (0→7→6); holding longer gives no repeat.
  - Press bounce shorter than 3 cycles → no step.
- Simultaneous events: step_ev in the same cycle as auto_ev in UP from sel=2 → sel=3 only, a single tick.
- rst_n asserted mid-scan at sel=6 in PINGPONG → sel=0, dir=0, tick=0 immediately (no clock needed); scan resumes from 0 after release.

Source files
------------

// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared encodings for the decoder scan sequencer: scan modes, select width
// and direction values.
package decoder_scan_ctrl_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'b00,
    MODE_UP       = 2'b01,
    MODE_DOWN     = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam logic [SEL_W-1:0] SEL_MIN = '0;
  localparam logic [SEL_W-1:0] SEL_MAX = '1;

endpackage

// File: rtl/decoder_scan_ctrl_sync_debounce.sv
// Two-flop synchroniser plus debouncer for one asynchronous board input.
// The clean output follows the synchronised level only after it has held a new value long enough.
module sync_debounce
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_clean;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      // The count tracks how long the synchronised level has disagreed with clean.
      if (r_sync == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_clean <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign clean = r_clean;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Select sequencer for the 3-to-8 LED decoder: manual switches, up/down count
// or ping-pong scan, advanced by a prescaler or a debounced single-step button.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] SW_in,
  input  logic             step_btn,
  input  logic [1:0]       mode,
  input  logic             run,
  output logic [SEL_W-1:0] sel,
  output logic             dir,
  output logic             tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [SEL_W-1:0] w_sw_clean;
  logic             w_step_clean;
  logic             w_step_ev;
  logic             w_auto_ev;
  logic             w_adv;
  logic             w_manual;
  logic             w_mode_chg;
  logic             w_presc_en;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_dir_nxt;
  logic             w_tick_nxt;
  mode_e            w_mode;

  logic             r_step_d;
  mode_e            r_mode_q;
  logic [PRE_W-1:0] r_presc;
  logic [SEL_W-1:0] r_sel;
  logic             r_dir;
  logic             r_tick;

  genvar gi;
  generate
    for (gi = 0; gi < SEL_W; gi++) begin : g_sw_deb
      sync_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_sw_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (SW_in[gi]),
        .clean(w_sw_clean[gi])
      );
    end
  endgenerate

  sync_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (step_btn),
    .clean(w_step_clean)
  );

  assign w_mode     = mode_e'(mode);
  assign w_manual   = (w_mode == MODE_MANUAL);
  assign w_mode_chg = (w_mode != r_mode_q);
  assign w_step_ev  = w_step_clean & ~r_step_d;

  // A mode change holds the prescaler at zero for that cycle so every mode starts a fresh period.
  assign w_presc_en = run & ~w_manual & ~w_mode_chg;
  assign w_auto_ev  = w_presc_en & (r_presc == PRE_LAST);
  assign w_adv      = (w_auto_ev | w_step_ev) & ~w_manual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_d <= 1'b0;
      r_mode_q <= MODE_MANUAL;
      r_presc  <= '0;
    end else begin
      r_step_d <= w_step_clean;
      r_mode_q <= w_mode;
      if (!w_presc_en || (r_presc == PRE_LAST)) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_nxt = r_sel;
    w_dir_nxt = r_dir;
    case (w_mode)
      MODE_MANUAL: begin
        w_sel_nxt = w_sw_clean;
        w_dir_nxt = DIR_UP;
      end
      MODE_UP: begin
        if (w_adv) begin
          w_sel_nxt = r_sel + 1'b1;
          w_dir_nxt = DIR_UP;
        end
      end
      MODE_DOWN: begin
        if (w_adv) begin
          w_sel_nxt = r_sel - 1'b1;
          w_dir_nxt = DIR_DN;
        end
      end
      MODE_PINGPONG: begin
        // The ends bounce back one step and flip direction in the same update.
        if (w_adv) begin
          if (r_dir == DIR_UP) begin
            if (r_sel == SEL_MAX) begin
              w_sel_nxt = SEL_MAX - 1'b1;
              w_dir_nxt = DIR_DN;
            end else begin
              w_sel_nxt = r_sel + 1'b1;
            end
          end else begin
            if (r_sel == SEL_MIN) begin
              w_sel_nxt = SEL_MIN + 1'b1;
              w_dir_nxt = DIR_UP;
            end else begin
              w_sel_nxt = r_sel - 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign w_tick_nxt = w_manual ? (w_sw_clean != r_sel) : w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_dir  <= DIR_UP;
      r_tick <= 1'b0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_dir  <= w_dir_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign sel  = r_sel;
  assign dir  = r_dir;
  assign tick = r_tick;

  a_tick_means_new_sel: assert property (
    @(posedge clk) disable iff (!rst_n) tick |-> (sel != $past(sel))
  );

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomised and directed bench for decoder_scan_ctrl, compared cycle by cycle
// against a behavioural model of the scan rules.
module tb_decoder_scan_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] SW_in;
  logic       step_btn;
  logic [1:0] mode;
  logic       run;
  logic [2:0] sel;
  logic       dir;
  logic       tick;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SW_in   (SW_in),
    .step_btn(step_btn),
    .mode    (mode),
    .run     (run),
    .sel     (sel),
    .dir     (dir),
    .tick    (tick)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: raw inputs reach the debouncer two edges late, a new
  // level must persist DEB_CYCLES edges, and the scan rules act on sel/dir.
  int m_s1[4], m_s2[4], m_cnt[4], m_clean[4];
  int m_step_prev, m_pmode, m_presc;
  int m_sel, m_dir, m_tick;

  always @(posedge clk or negedge rst_n) begin : model
    int raw[4];
    int sw, step_ev, mchg, act, auto_ev, adv, ns, nd, d;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_clean[i] = 0;
      end
      m_step_prev = 0; m_pmode = 0; m_presc = 0;
      m_sel = 0; m_dir = 0; m_tick = 0;
    end else begin
      raw[0] = int'(SW_in[0]); raw[1] = int'(SW_in[1]);
      raw[2] = int'(SW_in[2]); raw[3] = int'(step_btn);
      sw      = m_clean[0] + 2 * m_clean[1] + 4 * m_clean[2];
      step_ev = (m_clean[3] == 1 && m_step_prev == 0) ? 1 : 0;
      mchg    = (int'(mode) != m_pmode) ? 1 : 0;
      act     = (run && mode != 2'd0 && mchg == 0) ? 1 : 0;
      auto_ev = (act == 1 && m_presc == TICK_DIV - 1) ? 1 : 0;
      adv     = ((auto_ev == 1 || step_ev == 1) && mode != 2'd0) ? 1 : 0;
      ns = m_sel;
      nd = m_dir;
      if (mode == 2'd0) begin
        ns = sw;
        nd = 0;
      end else if (adv == 1) begin
        if (mode == 2'd1) begin
          ns = (m_sel + 1) % 8; nd = 0;
        end else if (mode == 2'd2) begin
          ns = (m_sel + 7) % 8; nd = 1;
        end else begin
          d = m_dir;
          if (d == 0 && m_sel == 7) d = 1;
          else if (d == 1 && m_sel == 0) d = 0;
          ns = (d == 1) ? m_sel - 1 : m_sel + 1;
          nd = d;
        end
      end
      m_tick = (ns != m_sel) ? 1 : 0;
      m_sel  = ns;
      m_dir  = nd;
      m_presc = (act == 1) ? (m_presc + 1) % TICK_DIV : 0;
      m_pmode = int'(mode);
      m_step_prev = m_clean[3];
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_clean[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB_CYCLES) begin
            m_clean[i] = m_s2[i];
            m_cnt[i]   = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel", int'(sel), m_sel);
      chk("dir", int'(dir), m_dir);
      chk("tick", int'(tick), m_tick);
    end
  end

  initial begin
    int hold;
    int ticks;
    int prev_sel;
    int found;

    rst_n = 1'b0; SW_in = 3'd0; step_btn = 1'b0; mode = 2'd0; run = 1'b0;
    #12;
    chk("rst_sel", int'(sel), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_tick", int'(tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // MANUAL: clean edge reaches sel six edges later
    SW_in = 3'b101;
    repeat (5) @(negedge clk);
    chk("man_early_sel", int'(sel), 0);
    @(negedge clk);
    chk("man_sel", int'(sel), 5);
    chk("man_tick", int'(tick), 1);
    @(negedge clk);
    chk("man_tick_once", int'(tick), 0);

    // MANUAL: 2-cycle glitch is filtered
    SW_in = 3'b010;
    repeat (2) @(negedge clk);
    SW_in = 3'b101;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ticks += int'(tick);
    end
    chk("glitch_sel", int'(sel), 5);
    chk("glitch_ticks", ticks, 0);

    // DOWN with run=0: button presses step once each
    SW_in = 3'b000;
    repeat (10) @(negedge clk);
    chk("down_start", int'(sel), 0);
    mode = 2'd2;
    step_btn = 1'b1;
    repeat (5) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("down_press1", int'(sel), 7);
    chk("down_dir", int'(dir), 1);
    step_btn = 1'b1;
    repeat (15) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("down_press2_long", int'(sel), 6);
    step_btn = 1'b1;
    repeat (2) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("down_bounce", int'(sel), 6);

    // UP from sel=1: auto step to 2, then step_ev and auto_ev coincide -> 3 only
    mode = 2'd0; SW_in = 3'd1;
    repeat (10) @(negedge clk);
    mode = 2'd1; run = 1'b1;
    repeat (3) @(negedge clk);
    step_btn = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ticks += int'(tick);
      if (i == 5) begin
        step_btn = 1'b0;
        chk("simul_before", int'(sel), 2);
      end
    end
    chk("simul_sel", int'(sel), 3);
    chk("simul_ticks", ticks, 2);

    // UP free-running: each tick advances sel by exactly one
    prev_sel = int'(sel);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) begin
        chk("up_step", int'(sel), (prev_sel + 1) % 8);
        prev_sel = int'(sel);
      end
    end

    // Randomised phase
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 24) == 0) SW_in = 3'($urandom_range(0, 7));
      if (hold > 0) begin
        hold--;
        if (hold == 0) step_btn = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        step_btn = 1'b1;
        hold = $urandom_range(1, 8);
      end
    end

    // PINGPONG, then asynchronous reset while sel=6
    step_btn = 1'b0;
    mode = 2'd3; run = 1'b1;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (sel == 3'd6) found = 1;
    end
    if (found == 0) chk("wait_sel6", int'(sel), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", int'(sel), 0);
    chk("async_rst_dir", int'(dir), 0);
    chk("async_rst_tick", int'(tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
